// File: rtl/td4_core.sv
// ============================================================================
// Module   : td4_core
// Brief    : TD4-style 4-bit single-cycle CPU core (A/B registers, carry, PC).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module td4_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry
);

  localparam logic [1:0] c_src_a    = 2'd0;
  localparam logic [1:0] c_src_b    = 2'd1;
  localparam logic [1:0] c_src_in   = 2'd2;
  localparam logic [1:0] c_src_zero = 2'd3;

  logic [3:0] r_pc;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_out;
  logic       r_carry;

  logic [3:0] w_op;
  logic [3:0] w_im;
  logic [1:0] w_sel;
  logic [3:0] w_src;
  logic [4:0] w_sum;
  logic       w_wr_a;
  logic       w_wr_b;
  logic       w_wr_out;
  logic       w_jmp;
  logic       w_nop;

  assign w_op = rom_data[7:4];
  assign w_im = rom_data[3:0];

  always_comb begin
    w_sel    = c_src_zero;
    w_wr_a   = 1'b0;
    w_wr_b   = 1'b0;
    w_wr_out = 1'b0;
    w_jmp    = 1'b0;
    w_nop    = 1'b0;
    case (w_op)
      4'b0000: begin w_sel = c_src_a;    w_wr_a = 1'b1; end
      4'b0001: begin w_sel = c_src_b;    w_wr_a = 1'b1; end
      4'b0010: begin w_sel = c_src_in;   w_wr_a = 1'b1; end
      4'b0011: begin w_sel = c_src_zero; w_wr_a = 1'b1; end
      4'b0100: begin w_sel = c_src_a;    w_wr_b = 1'b1; end
      4'b0101: begin w_sel = c_src_b;    w_wr_b = 1'b1; end
      4'b0110: begin w_sel = c_src_in;   w_wr_b = 1'b1; end
      4'b0111: begin w_sel = c_src_zero; w_wr_b = 1'b1; end
      4'b1001: begin w_sel = c_src_b;    w_wr_out = 1'b1; end
      4'b1011: begin w_sel = c_src_zero; w_wr_out = 1'b1; end
      4'b1111: begin w_sel = c_src_zero; w_jmp = 1'b1; end
      // JNC tests the flag left by the previous instruction
      4'b1110: begin w_sel = c_src_zero; w_jmp = ~r_carry; end
      default: w_nop = 1'b1;
    endcase
  end

  always_comb begin
    w_src = 4'd0;
    case (w_sel)
      c_src_a:  w_src = r_a;
      c_src_b:  w_src = r_b;
      c_src_in: w_src = in_port;
      default:  w_src = 4'd0;
    endcase
  end

  assign w_sum = {1'b0, w_src} + {1'b0, w_im};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 4'd0;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_out   <= 4'd0;
      r_carry <= 1'b0;
    end else if (en) begin
      r_carry <= w_nop ? 1'b0 : w_sum[4];
      r_pc    <= w_jmp ? w_sum[3:0] : r_pc + 4'd1;
      if (w_wr_a)   r_a   <= w_sum[3:0];
      if (w_wr_b)   r_b   <= w_sum[3:0];
      if (w_wr_out) r_out <= w_sum[3:0];
    end
  end

  assign rom_addr = r_pc;
  assign out_port = r_out;
  assign reg_a    = r_a;
  assign reg_b    = r_b;
  assign carry    = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_td4_core.sv
// ============================================================================
// Module   : tb_td4_core
// Brief    : Self-checking bench for td4_core with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  logic [7:0] rom [16];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_c;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  td4_core dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry)
  );

  // Instruction-level reference: one call retires one instruction
  task automatic model_exec(input logic [7:0] ins, input logic [3:0] inp);
    int op, im, s;
    bit jump;
    op = int'(ins[7:4]);
    im = int'(ins[3:0]);
    s = 0;
    jump = 0;
    case (op)
      0:  begin s = m_a + im; m_a = s[3:0]; end
      1:  begin s = m_b + im; m_a = s[3:0]; end
      2:  begin s = inp + im; m_a = s[3:0]; end
      3:  begin s = im;       m_a = s[3:0]; end
      4:  begin s = m_a + im; m_b = s[3:0]; end
      5:  begin s = m_b + im; m_b = s[3:0]; end
      6:  begin s = inp + im; m_b = s[3:0]; end
      7:  begin s = im;       m_b = s[3:0]; end
      9:  begin s = m_b + im; m_out = s[3:0]; end
      11: begin s = im;       m_out = s[3:0]; end
      15: begin s = im; jump = 1; end
      14: begin s = im; jump = (m_c == 1'b0); end
      default: s = 0;
    endcase
    m_c  = (s > 15);
    m_pc = jump ? 4'(im) : 4'((m_pc + 1) % 16);
  endtask

  task automatic clear_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) rom[i] = fill;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
  endtask

  task automatic tick();
    if (en) model_exec(rom[m_pc], in_port);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if ({rom_addr, reg_a, reg_b, carry, out_port} !== 17'd0) begin
      $display("FAIL reset_state: got %h expected %h",
               {rom_addr, reg_a, reg_b, carry, out_port}, 17'd0);
      errors++;
    end
    checks++;
  endtask

  task automatic test_mov_add();
    apply_reset();
    clear_rom(8'h80);
    rom[0] = 8'h31;
    rom[1] = 8'h0F;
    tick();
    if (reg_a !== 4'd1) begin
      $display("FAIL mov_a_im: got %h expected %h", reg_a, 4'd1); errors++;
    end
    checks++;
    tick();
    if ({reg_a, carry, rom_addr} !== {4'd0, 1'b1, 4'd2}) begin
      $display("FAIL add_wrap_carry: got a=%h c=%b pc=%h expected a=0 c=1 pc=2",
               reg_a, carry, rom_addr);
      errors++;
    end
    checks++;
  endtask

  task automatic test_jnc();
    apply_reset();
    clear_rom(8'h80);
    rom[0] = 8'h31; rom[1] = 8'h0F; rom[2] = 8'hE7; rom[3] = 8'hE7;
    tick(); tick();
    tick();
    if ({rom_addr, carry} !== {4'd3, 1'b0}) begin
      $display("FAIL jnc_not_taken: got pc=%h c=%b expected pc=3 c=0", rom_addr, carry);
      errors++;
    end
    checks++;
    tick();
    if (rom_addr !== 4'd7) begin
      $display("FAIL jnc_taken: got pc=%h expected pc=7", rom_addr); errors++;
    end
    checks++;
  endtask

  task automatic test_in_out();
    apply_reset();
    clear_rom(8'h80);
    rom[0] = 8'h60; rom[1] = 8'h93;
    in_port = 4'hA;
    tick();
    if (reg_b !== 4'hA) begin
      $display("FAIL in_b: got %h expected %h", reg_b, 4'hA); errors++;
    end
    checks++;
    in_port = 4'h0;
    tick();
    if ({out_port, carry} !== {4'hD, 1'b0}) begin
      $display("FAIL out_b: got out=%h c=%b expected out=d c=0", out_port, carry);
      errors++;
    end
    checks++;
  endtask

  task automatic test_wrap();
    apply_reset();
    clear_rom(8'h80);
    rom[0] = 8'h36; rom[1] = 8'h79;
    for (int i = 0; i < 15; i++) tick();
    if (rom_addr !== 4'd15) begin
      $display("FAIL pc_at_15: got %h expected %h", rom_addr, 4'd15); errors++;
    end
    checks++;
    tick();
    if ({rom_addr, carry} !== {4'd0, 1'b0}) begin
      $display("FAIL pc_wrap: got pc=%h c=%b expected pc=0 c=0", rom_addr, carry);
      errors++;
    end
    checks++;
    rom[0] = 8'hF5;
    tick();
    if ({rom_addr, reg_a, reg_b} !== {4'd5, 4'd6, 4'd9}) begin
      $display("FAIL jmp: got pc=%h a=%h b=%h expected pc=5 a=6 b=9",
               rom_addr, reg_a, reg_b);
      errors++;
    end
    checks++;
  endtask

  task automatic test_en_hold();
    rom[5] = 8'hB7;
    rom[6] = 8'h20;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_port = 4'(i * 5 + 3);
      tick();
    end
    if ({rom_addr, reg_a, reg_b, carry, out_port} !== {4'd6, 4'd6, 4'd9, 1'b0, 4'd7}) begin
      $display("FAIL en_hold: got %h expected %h",
               {rom_addr, reg_a, reg_b, carry, out_port}, {4'd6, 4'd6, 4'd9, 1'b0, 4'd7});
      errors++;
    end
    checks++;
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    clear_rom(8'h80);
    rom[0] = 8'h35; rom[1] = 8'hB3; rom[2] = 8'h0F;
    tick(); tick();
    if ({reg_a, out_port} !== {4'd5, 4'd3}) begin
      $display("FAIL pre_reset: got a=%h out=%h expected a=5 out=3", reg_a, out_port);
      errors++;
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if ({rom_addr, reg_a, reg_b, carry, out_port} !== 17'd0) begin
      $display("FAIL async_reset: got %h expected %h",
               {rom_addr, reg_a, reg_b, carry, out_port}, 17'd0);
      errors++;
    end
    checks++;
    #1;
    rst = 1'b0;
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
    rom[0] = 8'h31;
    tick();
    if ({rom_addr, reg_a} !== {4'd1, 4'd1}) begin
      $display("FAIL fetch_after_reset: got pc=%h a=%h expected pc=1 a=1", rom_addr, reg_a);
      errors++;
    end
    checks++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0)
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      in_port = 4'($urandom);
      tick();
      if ({rom_addr, reg_a, reg_b, carry, out_port} !== {m_pc, m_a, m_b, m_c, m_out}) begin
        $display("FAIL random_step%0d: got %h expected %h", n,
                 {rom_addr, reg_a, reg_b, carry, out_port}, {m_pc, m_a, m_b, m_c, m_out});
        errors++;
      end
      checks++;
    end
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    in_port = 4'd0;
    clear_rom(8'h80);
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
    #2;
    test_reset();
    test_mov_add();
    test_jnc();
    test_in_out();
    test_wrap();
    test_en_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
